// File: rtl/decode_inst_queue.sv
// Instruction packet queue between the decoder and the enabled pipeline
// register in front of rename/issue. First-word fall-through FIFO: the head
// entry is always visible on out_data. Occupancy comes from a count register,
// so equal head and tail pointers are never used to tell full from empty.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high. in_ready depends only on registered state (and reset), never on
// out_ready. out_valid/out_data hold until popped, flushed or reset.
module decode_inst_queue #(
  parameter int WIDTH = 154,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push, pop;

  // Status flags derive from the occupancy count only.
  assign full      = (count_q == CNTW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = ~full & ~reset;
  assign out_valid = ~empty;
  assign out_data  = mem_q[head_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state for pointers and count; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and storage; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push && !flush) mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Bench for decode_inst_queue: directed sequences, a small vector table and
// a random phase, all checked against a queue-based reference model.
module tb_decode_inst_queue;

  localparam int W     = 154;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;

  decode_inst_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: packets accepted and not yet consumed, oldest first.
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Occupancy must never exceed DEPTH.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (count > CNTW'(DEPTH)) begin
        n_err++;
        $display("FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
      end
    end
  end

  // Compare all outputs against the model state.
  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, "_count"}, W'(count), W'(sz));
    chk({tag, "_out_valid"}, W'(out_valid), W'(sz > 0));
    chk({tag, "_empty"}, W'(empty), W'(sz == 0));
    chk({tag, "_full"}, W'(full), W'(sz == DEPTH));
    chk({tag, "_in_ready"}, W'(in_ready), W'(sz < DEPTH));
    if (sz > 0) chk({tag, "_out_data"}, out_data, exp_q[0]);
  endtask

  // One clock cycle: check state, drive inputs, update model at the edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit do_push, do_pop;
    @(negedge clk);
    check_state("pre");
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    do_pop  = (exp_q.size() > 0) && ordy;
    do_push = iv && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        chk("popped_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back(d);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] data;
    logic         ordy;
    int           exp_cnt;
    logic         exp_v;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t tbl[10];

  logic [W-1:0] wide_a, wide_b, rnd;
  logic         hold_iv;
  logic [W-1:0] hold_d;

  initial begin
    // Fill-and-drain table: expected values after each edge.
    tbl[0] = '{1'b1, W'(1), 1'b0, 1, 1'b1, W'(1)};
    tbl[1] = '{1'b1, W'(2), 1'b0, 2, 1'b1, W'(1)};
    tbl[2] = '{1'b1, W'(3), 1'b0, 3, 1'b1, W'(1)};
    tbl[3] = '{1'b1, W'(4), 1'b0, 4, 1'b1, W'(1)};
    tbl[4] = '{1'b1, W'(5), 1'b0, 4, 1'b1, W'(1)};
    tbl[5] = '{1'b0, W'(0), 1'b1, 3, 1'b1, W'(2)};
    tbl[6] = '{1'b0, W'(0), 1'b1, 2, 1'b1, W'(3)};
    tbl[7] = '{1'b0, W'(0), 1'b1, 1, 1'b1, W'(4)};
    tbl[8] = '{1'b0, W'(0), 1'b1, 0, 1'b0, W'(0)};
    tbl[9] = '{1'b0, W'(0), 1'b1, 0, 1'b0, W'(0)};

    // Reset asserted before the first edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_count", W'(count), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_empty", W'(empty), W'(1));
    chk("rst_full", W'(full), W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rel_in_ready", W'(in_ready), W'(1));
    chk("rel_empty", W'(empty), W'(1));

    // Empty latency: no bypass, visible after the pushing edge.
    @(negedge clk);
    chk("lat_before_valid", W'(out_valid), W'(0));
    step(1'b1, W'(12'hABC), 1'b0, 1'b0);
    chk("lat_after_valid", W'(out_valid), W'(1));
    chk("lat_after_data", out_data, W'(12'hABC));
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill and drain through the table.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].data, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d_count", i), W'(count), W'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_d);
    end

    // Simultaneous push/pop at count 2; pointers wrap several times.
    step(1'b1, W'(8'h20), 1'b0, 1'b0);
    step(1'b1, W'(8'h21), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(8'h10 + i), 1'b1, 1'b0);
      chk("simul_count", W'(count), W'(2));
    end
    chk("simul_head", out_data, W'(8'h18));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("simul_empty", W'(empty), W'(1));

    // Flush beats a simultaneous push and pop.
    step(1'b1, W'(8'h30), 1'b0, 1'b0);
    step(1'b1, W'(8'h31), 1'b0, 1'b0);
    step(1'b1, W'(8'h32), 1'b0, 1'b0);
    chk("flush_pre_count", W'(count), W'(3));
    step(1'b1, W'(7), 1'b1, 1'b1);
    chk("flush_count", W'(count), W'(0));
    chk("flush_valid", W'(out_valid), W'(0));
    step(1'b1, W'(8), 1'b0, 1'b0);
    chk("flush_next_data", out_data, W'(8));
    step(1'b0, '0, 1'b1, 1'b0);

    // Full-width packets read back bit-exact.
    wide_a = '0;
    wide_a[W-1] = 1'b1;
    wide_a[0] = 1'b1;
    wide_b = '1;
    step(1'b1, wide_a, 1'b0, 1'b0);
    step(1'b1, wide_b, 1'b0, 1'b0);
    chk("wide_a", out_data, wide_a);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("wide_b", out_data, wide_b);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic; an unaccepted offer is held stable.
    hold_iv = 1'b0;
    hold_d  = '0;
    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (!hold_iv) begin
        hold_iv = 1'($urandom_range(0, 1));
        hold_d  = rnd;
      end
      step(hold_iv, hold_d, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1] === hold_d) hold_iv = 1'b0;
      else if (exp_q.size() == 0) hold_iv = 1'b0;
    end

    // Reset mid-cycle discards entries without a clock edge.
    step(1'b1, W'(8'h55), 1'b0, 1'b0);
    step(1'b1, W'(8'h56), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(0));
    chk("mid_rst_count", W'(count), W'(0));
    chk("mid_rst_data", out_data, W'(0));
    @(negedge clk) reset = 1'b0;
    #1;
    chk("mid_rel_in_ready", W'(in_ready), W'(1));
    chk("mid_rel_empty", W'(empty), W'(1));
    step(1'b1, W'(8'h77), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
